// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline:
// load-type encodings and the hard-wired zero register.
package mips_pkg;
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Sub-word load alignment and extension.
// Reports LW/LH/LHU accesses that are not naturally aligned.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_load_type,
    output logic [31:0] o_data,
    output logic        o_misalign
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Encodings 5-7 fall through to the LW behaviour.
    always_comb begin
        o_data     = i_rdata;
        o_misalign = (i_addr_lo != 2'b00);
        case (i_load_type)
            LD_LB: begin
                o_data     = {{24{w_byte[7]}}, w_byte};
                o_misalign = 1'b0;
            end
            LD_LBU: begin
                o_data     = {24'd0, w_byte};
                o_misalign = 1'b0;
            end
            LD_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            LD_LHU: begin
                o_data     = {16'd0, w_half};
                o_misalign = i_addr_lo[0];
            end
            default: begin
                o_data     = i_rdata;
                o_misalign = (i_addr_lo != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back formatter.
// Drives the register-file write port and the retire counter.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             MemValid,
    input  logic             MemRegWrite,
    input  logic             MemToReg,
    input  logic [2:0]       MemLoadType,
    input  logic [1:0]       MemAddrLo,
    input  logic [31:0]      MemRdata,
    input  logic [31:0]      MemAluResult,
    input  logic [4:0]       MemWriteR,
    output logic             RegWrite,
    output logic [4:0]       WriteR,
    output logic [31:0]      WriteD,
    output logic             WbValid,
    output logic             MisalignErr,
    output logic [CNT_W-1:0] RetireCount
);
    logic [31:0] w_al_data;
    logic        w_al_mis;
    logic        w_mis;
    logic        w_rw;
    logic [31:0] w_wd;

    logic             r_rw;
    logic [4:0]       r_wr;
    logic [31:0]      r_wd;
    logic             r_valid;
    logic             r_mis;
    logic [CNT_W-1:0] r_cnt;

    load_align u_align (
        .i_rdata     (MemRdata),
        .i_addr_lo   (MemAddrLo),
        .i_load_type (MemLoadType),
        .o_data      (w_al_data),
        .o_misalign  (w_al_mis)
    );

    assign w_mis = MemValid & MemToReg & w_al_mis;
    assign w_rw  = MemValid & MemRegWrite
                 & (MemWriteR != REG_ZERO) & ~w_mis;
    assign w_wd  = MemToReg ? w_al_data : MemAluResult;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rw    <= 1'b0;
            r_wr    <= '0;
            r_wd    <= '0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_cnt   <= '0;
        end else if (Flush) begin
            r_rw    <= 1'b0;
            r_wr    <= '0;
            r_wd    <= '0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
        end else if (!Stall) begin
            r_rw    <= w_rw;
            r_wr    <= MemWriteR;
            r_wd    <= w_wd;
            r_valid <= MemValid;
            r_mis   <= w_mis;
            r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, MemValid};
        end
    end

    assign RegWrite    = r_rw;
    assign WriteR      = r_wr;
    assign WriteD      = r_wd;
    assign WbValid     = r_valid;
    assign MisalignErr = r_mis;
    assign RetireCount = r_cnt;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage (32-bit and 4-bit counter instances).
module tb_mem_wb_stage;
    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, MemValid, MemRegWrite, MemToReg;
    logic [2:0]  MemLoadType;
    logic [1:0]  MemAddrLo;
    logic [31:0] MemRdata, MemAluResult;
    logic [4:0]  MemWriteR;

    logic        RegWrite, WbValid, MisalignErr;
    logic [4:0]  WriteR;
    logic [31:0] WriteD, RetireCount;
    logic        b_rw, b_valid, b_mis;
    logic [4:0]  b_wr;
    logic [31:0] b_wd;
    logic [3:0]  b_cnt;

    always #5 Clk = ~Clk;

    mem_wb_stage #(.CNT_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .MemValid(MemValid), .MemRegWrite(MemRegWrite),
        .MemToReg(MemToReg), .MemLoadType(MemLoadType),
        .MemAddrLo(MemAddrLo), .MemRdata(MemRdata),
        .MemAluResult(MemAluResult), .MemWriteR(MemWriteR),
        .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
        .WbValid(WbValid), .MisalignErr(MisalignErr),
        .RetireCount(RetireCount)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .MemValid(MemValid), .MemRegWrite(MemRegWrite),
        .MemToReg(MemToReg), .MemLoadType(MemLoadType),
        .MemAddrLo(MemAddrLo), .MemRdata(MemRdata),
        .MemAluResult(MemAluResult), .MemWriteR(MemWriteR),
        .RegWrite(b_rw), .WriteR(b_wr), .WriteD(b_wd),
        .WbValid(b_valid), .MisalignErr(b_mis),
        .RetireCount(b_cnt)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fmt(logic [2:0] lt,
                                        logic [1:0] a,
                                        logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*a +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (lt)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'd0, b};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'd0, h};
            default: return d;
        endcase
    endfunction

    function automatic logic misal(logic [2:0] lt, logic [1:0] a);
        if (lt == 3'd1 || lt == 3'd2) return 1'b0;
        if (lt == 3'd3 || lt == 3'd4) return a[0];
        return a != 2'd0;
    endfunction

    // Drive one cycle, advance the model, then compare at posedge+1.
    task automatic drive(input logic r, f, s, v, rw, mtr,
                         input logic [2:0] lt,
                         input logic [1:0] a,
                         input logic [31:0] rd, alu,
                         input logic [4:0] wr);
        exp_t e;
        logic mis;
        Rst = r; Flush = f; Stall = s; MemValid = v;
        MemRegWrite = rw; MemToReg = mtr; MemLoadType = lt;
        MemAddrLo = a; MemRdata = rd; MemAluResult = alu;
        MemWriteR = wr;
        if (r) begin
            m = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0};
        end else if (f) begin
            m.rw = 0; m.wr = 0; m.wd = 0; m.valid = 0; m.mis = 0;
        end else if (!s) begin
            mis     = v && mtr && misal(lt, a);
            m.mis   = mis;
            m.rw    = v && rw && (wr != 5'd0) && !mis;
            m.wr    = wr;
            m.wd    = mtr ? fmt(lt, a, rd) : alu;
            m.valid = v;
            if (v) begin
                m.cnt  = m.cnt + 1;
                m.cnt4 = m.cnt4 + 4'd1;
            end
        end
        sb.push_back(m);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
        check("WriteR", {27'd0, WriteR}, {27'd0, e.wr});
        check("WriteD", WriteD, e.wd);
        check("WbValid", {31'd0, WbValid}, {31'd0, e.valid});
        check("MisalignErr", {31'd0, MisalignErr}, {31'd0, e.mis});
        check("RetireCount", RetireCount, e.cnt);
        check("RetireCount4", {28'd0, b_cnt}, {28'd0, e.cnt4});
    endtask

    localparam logic [31:0] RD = 32'h8070_F0A5;
    logic [31:0] cnt_before;

    initial begin
        m = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0};
        // Reset for two cycles with a valid instruction present
        drive(1, 0, 0, 1, 1, 0, 0, 0, RD, 32'h1234, 5'd7);
        drive(1, 1, 1, 1, 1, 0, 0, 0, RD, 32'h1234, 5'd7);
        check("rst_cnt", RetireCount, 32'd0);
        // ALU op
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFF6, 5'd8);
        check("alu_wd", WriteD, 32'hFFFF_FFF6);
        check("alu_cnt", RetireCount, 32'd1);
        // Loads
        drive(0, 0, 0, 1, 1, 1, 3'd1, 2'd0, RD, 0, 5'd3);
        check("lb", WriteD, 32'hFFFF_FFA5);
        drive(0, 0, 0, 1, 1, 1, 3'd2, 2'd1, RD, 0, 5'd3);
        check("lbu", WriteD, 32'h0000_00F0);
        drive(0, 0, 0, 1, 1, 1, 3'd3, 2'd2, RD, 0, 5'd3);
        check("lh", WriteD, 32'hFFFF_8070);
        drive(0, 0, 0, 1, 1, 1, 3'd4, 2'd2, RD, 0, 5'd3);
        check("lhu", WriteD, 32'h0000_8070);
        drive(0, 0, 0, 1, 1, 1, 3'd0, 2'd0, RD, 0, 5'd3);
        check("lw", WriteD, RD);
        drive(0, 0, 0, 1, 1, 1, 3'd6, 2'd3, RD, 0, 5'd3);
        // Misaligned loads
        drive(0, 0, 0, 1, 1, 1, 3'd0, 2'd2, RD, 0, 5'd4);
        check("mis_lw", {31'd0, MisalignErr}, 32'd1);
        drive(0, 0, 0, 1, 1, 1, 3'd3, 2'd1, RD, 0, 5'd4);
        check("mis_lh_rw", {31'd0, RegWrite}, 32'd0);
        // Write to $0 suppressed
        drive(0, 0, 0, 1, 1, 0, 0, 0, RD, 32'h55, 5'd0);
        // Bubble, then stall x3, then flush+stall
        drive(0, 0, 0, 0, 1, 0, 0, 0, RD, 32'h77, 5'd9);
        drive(0, 0, 0, 1, 1, 0, 0, 0, RD, 32'hABCD, 5'd10);
        cnt_before = RetireCount;
        for (int i = 0; i < 3; i++)
            drive(0, 0, 1, 1, 1, 1, 3'd1, 2'(i), RD, 32'd0, 5'd11);
        check("stall_wd", WriteD, 32'hABCD);
        drive(0, 1, 1, 1, 1, 0, 0, 0, RD, 32'h99, 5'd12);
        check("flush_valid", {31'd0, WbValid}, 32'd0);
        check("seq_cnt", RetireCount, cnt_before);
        // Reset during stall
        drive(0, 0, 0, 1, 1, 0, 0, 0, RD, 32'h42, 5'd13);
        drive(1, 0, 1, 1, 1, 0, 0, 0, RD, 32'h43, 5'd14);
        // Sixteen retires wrap the 4-bit counter
        for (int i = 0; i < 16; i++)
            drive(0, 0, 0, 1, 1, 0, 0, 0, RD, 32'(i), 5'd1);
        check("wrap4", {28'd0, b_cnt}, 32'd0);
        check("cnt16", RetireCount, 32'd16);
        // Random traffic
        for (int i = 0; i < 60; i++)
            drive(($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 4) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 2'($urandom), $urandom, $urandom,
                  5'($urandom_range(0, 3)));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
